// File: rtl/soc_code_ram_loader.sv
// Runtime loader for the code RAM: packs a byte stream little-endian into words, writes them
// from address 0, then reads every word back and reports an XOR checksum and a mismatch flag.
module soc_code_ram_loader #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 12
) (
  input  logic                 PortAClk,
  input  logic                 PortAResetN,
  input  logic                 Start,
  input  logic [ADDRWIDTH:0]   WordCount,
  input  logic                 ByteValid,
  input  logic [7:0]           ByteData,
  output logic                 ByteReady,
  output logic [ADDRWIDTH-1:0] PortAAddr,
  output logic [DATAWIDTH-1:0] PortADataIn,
  output logic                 PortAWriteEnable,
  input  logic [DATAWIDTH-1:0] PortADataOut,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] Checksum,
  output logic                 Mismatch
);

  localparam int BYTES = DATAWIDTH / 8;
  localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_VRD     = 3'd3,
    S_VCHK    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH:0]     n_q, n_d;
  logic [ADDRWIDTH-1:0]   idx_q, idx_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [DATAWIDTH-1:0]   word_q, word_d;
  logic [DATAWIDTH-1:0]   wxor_q, wxor_d;
  logic [DATAWIDTH-1:0]   rxor_q, rxor_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   din_q, din_d;
  logic [DATAWIDTH-1:0]   checksum_q, checksum_d;
  logic                   mismatch_q, mismatch_d;

  logic last_idx;
  logic last_lane;
  logic zero_req;

  assign last_idx  = ({1'b0, idx_q} == (n_q - (ADDRWIDTH + 1)'(1)));
  assign last_lane = (lane_q == LW'(BYTES - 1));
  assign zero_req  = (WordCount == '0);

  always_ff @(posedge PortAClk or negedge PortAResetN) begin
    if (!PortAResetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Start) state_d = zero_req ? S_DONE : S_COLLECT;
      S_COLLECT: if (ByteValid && last_lane) state_d = S_WRITE;
      S_WRITE:   state_d = last_idx ? S_VRD : S_COLLECT;
      S_VRD:     state_d = S_VCHK;
      S_VCHK:    state_d = last_idx ? S_DONE : S_VRD;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Address and write data are loaded on entry to WRITE/VRD so they are stable for the RAM.
  always_comb begin
    n_d        = n_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    word_d     = word_q;
    wxor_d     = wxor_q;
    rxor_d     = rxor_q;
    addr_d     = addr_q;
    din_d      = din_q;
    checksum_d = checksum_q;
    mismatch_d = mismatch_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          n_d        = (WordCount > DEPTH) ? DEPTH : WordCount;
          idx_d      = '0;
          lane_d     = '0;
          word_d     = '0;
          wxor_d     = '0;
          rxor_d     = '0;
          checksum_d = '0;
          mismatch_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (ByteValid) begin
          for (int k = 0; k < BYTES; k++) begin
            if (lane_q == LW'(k)) word_d[8*k +: 8] = ByteData;
          end
          if (last_lane) begin
            lane_d = '0;
            addr_d = idx_q;
            din_d  = word_d;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      S_WRITE: begin
        wxor_d = wxor_q ^ din_q;
        if (last_idx) begin
          idx_d  = '0;
          addr_d = '0;
        end else begin
          idx_d = idx_q + ADDRWIDTH'(1);
        end
      end
      S_VCHK: begin
        rxor_d = rxor_q ^ PortADataOut;
        if (last_idx) begin
          checksum_d = rxor_d;
          mismatch_d = (rxor_d != wxor_q);
        end else begin
          idx_d  = idx_q + ADDRWIDTH'(1);
          addr_d = idx_q + ADDRWIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PortAClk or negedge PortAResetN) begin
    if (!PortAResetN) begin
      n_q        <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      wxor_q     <= '0;
      rxor_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      checksum_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      wxor_q     <= wxor_d;
      rxor_q     <= rxor_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      checksum_q <= checksum_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    ByteReady        = (state_q == S_COLLECT);
    PortAWriteEnable = (state_q == S_WRITE);
    Busy             = (state_q == S_COLLECT) || (state_q == S_WRITE) ||
                       (state_q == S_VRD) || (state_q == S_VCHK);
    Done             = (state_q == S_DONE);
    PortAAddr        = addr_q;
    PortADataIn      = din_q;
    Checksum         = checksum_q;
    Mismatch         = mismatch_q;
  end

endmodule
